// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler: sizes, FSM states,
// and the round-robin pick used at every arbitration point.
package led_sched_pkg;

  localparam int NREQ  = 4;
  localparam int LED_W = 8;
  localparam int IDX_W = $clog2(NREQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } rr_res_t;

  // Scan farthest-first so the candidate nearest after 'last' is written last and wins.
  function automatic rr_res_t rr_next(input idx_t last, input logic [NREQ-1:0] req);
    rr_res_t res;
    idx_t    cand;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + idx_t'(k);
      if (req[cand]) begin
        res.vld = 1'b1;
        res.idx = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input idx_t idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_bank_sched_if.sv
// Requester-facing bus of the LED bank scheduler; master drives requests and
// patterns, slave is the scheduler returning grant, done, LED drive and tick.
interface led_bank_sched_if;
  import led_sched_pkg::*;

  logic                    fast_sel;
  logic [NREQ-1:0]         req;
  logic [NREQ*LED_W-1:0]   pat_in;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         done;
  logic [LED_W-1:0]        light;
  logic                    tick;
  logic                    busy;

  modport master (
    output fast_sel, req, pat_in,
    input  gnt, done, light, tick, busy
  );

  modport slave (
    input  fast_sel, req, pat_in,
    output gnt, done, light, tick, busy
  );

endinterface

// File: rtl/led_tick_gen.sv
// Tick divider: pulses o_tick on the last cycle of each period; the period
// length is only re-sampled at wrap so speed changes never cut a period short.
module led_tick_gen #(
  parameter int SLOW_DIV = 100000,
  parameter int FAST_DIV = 10000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_fast_sel,
  output logic o_tick
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_m1;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_div_m1);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_div_m1 <= SLOW_M1;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_div_m1 <= i_fast_sel ? FAST_M1 : SLOW_M1;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_bank_sched.sv
// Shares one 8-LED bank between four requesters: round-robin grant on a tick,
// bounded hold measured in ticks, and a blank gap tick between owners.
module led_bank_sched
  import led_sched_pkg::*;
#(
  parameter int SLOW_DIV   = 100000,
  parameter int FAST_DIV   = 10000,
  parameter int HOLD_TICKS = 8
) (
  input  logic            clk100khz,
  input  logic            rst_n,
  led_bank_sched_if.slave bus
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS - 1);

  state_t           r_state;
  idx_t             r_owner;
  idx_t             r_last;
  logic [7:0]       r_hold;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [LED_W-1:0] r_light;
  logic             r_busy;

  logic             w_tick;
  rr_res_t          w_rr;
  logic [LED_W-1:0] w_pat_owner;
  logic [LED_W-1:0] w_pat_win;
  logic             w_release;

  led_tick_gen #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick (
    .i_clk      (clk100khz),
    .i_rst_n    (rst_n),
    .i_fast_sel (bus.fast_sel),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_rr        = rr_next(r_last, bus.req);
    w_pat_owner = bus.pat_in[r_owner*LED_W +: LED_W];
    w_pat_win   = bus.pat_in[w_rr.idx*LED_W +: LED_W];
    // Expiry and owner release collapse into one exit, hence one done pulse.
    w_release   = (w_tick && (r_hold == '0)) || !bus.req[r_owner];
  end

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= idx_t'(NREQ - 1);
      r_hold  <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_light <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          r_light <= '0;
          if (w_tick && w_rr.vld) begin
            r_owner <= w_rr.idx;
            r_last  <= w_rr.idx;
            r_gnt   <= onehot(w_rr.idx);
            r_light <= w_pat_win;
            r_hold  <= HOLD_INIT;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_release) begin
            r_done  <= onehot(r_owner);
            r_gnt   <= '0;
            r_light <= '0;
            r_state <= GAP;
          end else begin
            r_light <= w_pat_owner;
            if (w_tick) r_hold <= r_hold - 1'b1;
          end
        end
        GAP: begin
          r_light <= '0;
          if (w_tick) begin
            if (w_rr.vld) begin
              r_owner <= w_rr.idx;
              r_last  <= w_rr.idx;
              r_gnt   <= onehot(w_rr.idx);
              r_light <= w_pat_win;
              r_hold  <= HOLD_INIT;
              r_state <= HOLD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_gnt   <= '0;
          r_light <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.light = r_light;
  assign bus.tick  = w_tick;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_led_bank_sched.sv
// Directed and randomized bench for led_bank_sched against a tick/hold model
// built from the scheduling rules (countdown to tick, ticks-seen per grant).
module tb_led_bank_sched;

  localparam int SLOW = 10;
  localparam int FAST = 2;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  led_bank_sched_if bus ();

  led_bank_sched #(
    .SLOW_DIV   (SLOW),
    .FAST_DIV   (FAST),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk100khz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 owned, 2 blank gap.
  int         m_rem;
  int         m_phase;
  int         m_owner;
  int         m_last;
  int         m_seen;
  logic [3:0] m_gnt;
  logic [3:0] m_done;
  logic [7:0] m_light;
  logic       m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rem   = SLOW - 1;
    m_phase = 0;
    m_owner = 0;
    m_last  = 3;
    m_seen  = 0;
    m_gnt   = '0;
    m_done  = '0;
    m_light = '0;
    m_busy  = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    int w;
    t      = (m_rem == 0);
    m_done = '0;
    if (m_phase == 1) begin
      if ((t && (m_seen + 1 == HOLD)) || !bus.req[m_owner]) begin
        m_done         = '0;
        m_done[m_owner] = 1'b1;
        m_gnt          = '0;
        m_light        = '0;
        m_phase        = 2;
      end else begin
        m_light = bus.pat_in[8*m_owner +: 8];
        if (t) m_seen++;
      end
    end else begin
      m_light = '0;
      if (t) begin
        w = pick(m_last, bus.req);
        if (w >= 0) begin
          m_owner  = w;
          m_last   = w;
          m_gnt    = '0;
          m_gnt[w] = 1'b1;
          m_light  = bus.pat_in[8*w +: 8];
          m_busy   = 1'b1;
          m_seen   = 0;
          m_phase  = 1;
        end else if (m_phase == 2) begin
          m_phase = 0;
          m_busy  = 1'b0;
        end
      end
    end
    m_rem = t ? ((bus.fast_sel ? FAST : SLOW) - 1) : (m_rem - 1);
  endtask

  task automatic check_outputs();
    chk("gnt",   32'(bus.gnt),   32'(m_gnt));
    chk("done",  32'(bus.done),  32'(m_done));
    chk("light", 32'(bus.light), 32'(m_light));
    chk("busy",  32'(bus.busy),  32'(m_busy));
    chk("tick",  32'(bus.tick),  32'(m_rem == 0));
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    chk("gnt_done_excl", 32'(bus.gnt & bus.done), 32'd0);
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] want, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.gnt === want) break;
      cycle();
    end
    chk(tag, 32'(bus.gnt), 32'(want));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   32'(bus.gnt),   32'd0);
    chk("rst_light", 32'(bus.light), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    bus.fast_sel = 1'b0;
    bus.req      = 4'b1111;
    bus.pat_in   = 32'h5581_33AA;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // All requesting: 0 first at the first tick, then 1 after hold and gap.
    run(10);
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    chk("first_light", 32'(bus.light), 32'hAA);
    run(30);
    chk("expire_done", 32'(bus.done), 32'h1);
    run(10);
    chk("second_gnt", 32'(bus.gnt), 32'h2);

    // Single requester 2 repeatedly re-wins after its gap.
    bus.req = 4'b0100;
    wait_gnt("only2_gnt", 4'b0100, 40);
    chk("only2_light", 32'(bus.light), 32'h81);
    run(90);

    // Owner drops mid-hold; owner pattern change shows next cycle.
    bus.req = 4'b0000;
    run(25);
    bus.req = 4'b0100;
    wait_gnt("drop_gnt", 4'b0100, 40);
    run(2);
    bus.pat_in = 32'h553C_33AA;
    cycle();
    chk("pat_follow", 32'(bus.light), 32'h3C);
    cycle();
    bus.req = 4'b0000;
    cycle();
    chk("drop_done", 32'(bus.done), 32'h4);
    chk("drop_light", 32'(bus.light), 32'h0);
    run(15);

    // Speed change mid-period.
    bus.req = 4'b0001;
    run(4);
    bus.fast_sel = 1'b1;
    run(30);
    bus.fast_sel = 1'b0;
    run(25);

    // Async reset during a hold.
    wait_gnt("pre_rst_gnt", 4'b0001, 40);
    run(2);
    async_reset();
    bus.req = 4'b1111;
    run(10);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);

    // Requester 1 releases on its own expiry tick.
    bus.req = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_phase == 1 && m_owner == 1 && m_rem == 0 && m_seen == HOLD - 1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("expiry_found", 32'(found), 32'd1);
    bus.req = 4'b0000;
    cycle();
    chk("expiry_drop_done", 32'(bus.done), 32'h2);
    chk("expiry_drop_gnt", 32'(bus.gnt), 32'h0);
    cycle();
    chk("expiry_single_done", 32'(bus.done), 32'h0);
    run(12);

    // Randomized traffic.
    bus.fast_sel = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.pat_in = $urandom;
      if ($urandom_range(0, 49) == 0) bus.fast_sel = ~bus.fast_sel;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
